// File: rtl/uart_prog_loader.sv
// Boot-time UART program loader: receives a framed image and writes it into instruction memory,
// holding the core in reset until the image is complete. Define UART_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module uart_prog_loader #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  output logic [15:0] im_addr_o,
  output logic [15:0] im_wdata_o,
  output logic        im_we_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] word_count_o
);
  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV + 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM    = 3'd7;
  localparam logic [2:0] S_AFTER   = S_CSUM;
`else
  localparam logic [2:0] S_AFTER   = S_DONE;
`endif

  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] im_addr_q, im_addr_d;
  logic [15:0] im_wdata_q, im_wdata_d;
  logic        im_we_q, im_we_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [15:0] word_count_q, word_count_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // Synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // Receiver: start re-checked at half bit, data and stop sampled at bit centres
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d      = '0;
          bit_idx_d  = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d     = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d        = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_s2_q;
          frame_err_d  = !rx_s2_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Frame parser; all outputs are registered from the next-state values
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    hi_d         = hi_q;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    im_we_d      = 1'b0;
    word_count_d = word_count_q;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (byte_valid_q) begin
      case (state_q)
        S_LEN_HI: begin
          len_d   = {shift_q, 8'h00};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d   = {len_q[15:8], shift_q};
          state_d = (len_d == 16'd0) ? S_AFTER : S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = shift_q;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          im_we_d      = 1'b1;
          im_addr_d    = word_count_q;
          im_wdata_d   = {hi_q, shift_q};
          word_count_d = word_count_q + 16'd1;
          state_d      = (word_count_d == len_q) ? S_AFTER : S_DATA_HI;
        end
`ifdef UART_LOADER_CHECKSUM_EN
        S_CSUM: state_d = (shift_q == csum_q) ? S_DONE : S_ERR;
`endif
        default: begin
          if (shift_q == SYNC_BYTE) begin
            state_d      = S_LEN_HI;
            word_count_d = 16'd0;
          end
        end
      endcase
`ifdef UART_LOADER_CHECKSUM_EN
      if (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) csum_d = 8'h00;
      else if (state_q != S_CSUM) csum_d = csum_q ^ shift_q;
`endif
    end
    if (frame_err_q && busy_q) state_d = S_ERR;
    busy_d     = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      len_q        <= 16'd0;
      hi_q         <= 8'h00;
      im_addr_q    <= 16'd0;
      im_wdata_q   <= 16'd0;
      im_we_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= 16'd0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      im_we_q      <= im_we_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
`ifdef UART_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign im_addr_o    = im_addr_q;
  assign im_wdata_o   = im_wdata_q;
  assign im_we_o      = im_we_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign word_count_o = word_count_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: frames built from word lists, expected writes queued, monitor checks each write.
module tb_uart_prog_loader;
  localparam int unsigned DIV = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [15:0] im_addr, im_wdata, word_count;
  logic        im_we, cpu_hold, busy, err;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] wds[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD       (100_000),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_i        (rx),
    .im_addr_o   (im_addr),
    .im_wdata_o  (im_wdata),
    .im_we_o     (im_we),
    .cpu_hold_o  (cpu_hold),
    .busy_o      (busy),
    .err_o       (err),
    .word_count_o(word_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", im_addr, im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(im_addr), 32'(e.a));
        chk("wr_data", 32'(im_wdata), 32'(e.d));
        chk("wr_count", 32'(word_count), 32'(e.a) + 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic fill_random(input int n);
    wds.delete();
    for (int i = 0; i < n; i++) wds.push_back(16'($urandom));
  endtask

  // Sends a frame of wds; bad_idx >= 1 gets a zero stop bit and ends the frame there
  task automatic run_frame(input int bad_idx, input bit bad_csum);
    logic [7:0] fb[$];
    logic [7:0] cs;
    int n, nw;
    bit ferr, cerr;
    n = wds.size();
    nw = 0;
    cerr = 1'b0;
    fb.push_back(8'hA5);
    fb.push_back(8'(n >> 8));
    fb.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      fb.push_back(wds[i][15:8]);
      fb.push_back(wds[i][7:0]);
    end
    cs = 8'h00;
    for (int i = 1; i < fb.size(); i++) cs = cs ^ fb[i];
`ifdef UART_LOADER_CHECKSUM_EN
    fb.push_back(bad_csum ? ~cs : cs);
    cerr = bad_csum;
`endif
    ferr = (bad_idx >= 1) && (bad_idx < fb.size());
    for (int i = 0; i < n; i++) begin
      if (!ferr || (4 + 2 * i) < bad_idx) begin
        exp_q.push_back({16'(i), wds[i]});
        nw++;
      end
    end
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], !(ferr && i == bad_idx));
      if (ferr && i == bad_idx) break;
    end
    repeat (DIV) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("cpu_hold", 32'(cpu_hold), 32'(ferr || cerr));
    chk("err", 32'(err), 32'(ferr || cerr));
    chk("busy", 32'(busy), 32'd0);
    chk("word_count", 32'(word_count), 32'(nw));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_wc"}, 32'(word_count), 32'd0);
    chk({tag, "_we"}, 32'(im_we), 32'd0);
    chk({tag, "_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(im_wdata), 32'd0);
  endtask

  initial begin
    int last_len;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10000) @(negedge clk);
    check_reset_outputs("idle");

    // Known frame, then a check mid-frame that busy is up
    wds.delete();
    wds.push_back(16'h1234);
    wds.push_back(16'hABCD);
    run_frame(-1, 1'b0);

    fork
      run_frame(-1, 1'b0);
      begin
        repeat (11 * DIV + 8) @(negedge clk);
        chk("busy_in_frame", 32'(busy), 32'd1);
        chk("hold_in_frame", 32'(cpu_hold), 32'd1);
      end
    join

`ifdef UART_LOADER_CHECKSUM_EN
    run_frame(-1, 1'b1);
    fill_random(3);
    run_frame(-1, 1'b0);
`endif

    wds.delete();
    run_frame(-1, 1'b0);

    // Framing error on second data byte, then on a later byte
    fill_random(3);
    run_frame(4, 1'b0);
    fill_random(3);
    run_frame(7, 1'b0);

    // Short glitch on idle line after a good frame must change nothing
    fill_random(2);
    run_frame(-1, 1'b0);
    last_len = 2;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    chk("glitch_hold", 32'(cpu_hold), 32'd0);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_wc", 32'(word_count), 32'(last_len));

    // Reset between DATA_HI and DATA_LO of the second word
    fill_random(2);
    exp_q.push_back({16'd0, wds[0]});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(wds[0][15:8], 1'b1);
    send_byte(wds[0][7:0], 1'b1);
    send_byte(wds[1][15:8], 1'b1);
    chk("pre_reset_writes", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    fill_random(4);
    run_frame(-1, 1'b0);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(0, 5));
      fill_random(n);
      if ($urandom_range(0, 3) == 0 && n > 0)
        run_frame(int'($urandom_range(1, 2 + 2 * n)), 1'b0);
      else
        run_frame(-1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
